biriscv_csr_wb_pipe: RTL and testbench

BIRISCV_CSR_WB_PIPE -- requirements
Module: biriscv_csr_wb_pipe

---
 rtl/biriscv_csr_wb_pipe.sv | 151 +++++++++++++++
 tb/tb_biriscv_csr_wb_pipe.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/biriscv_csr_wb_pipe.sv
// E2/WB writeback pipeline for CSR results: carries E1 results through two register
// stages, merges LSU faults, selects the trap value and drives the commit strobes.
module biriscv_csr_wb_pipe #(
  parameter int SUPPORT_SUPER = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        e1_valid_i,
  input  logic [31:0] e1_pc_i,
  input  logic [31:0] e1_opcode_i,
  input  logic [4:0]  e1_rd_idx_i,
  input  logic [31:0] csr_result_e1_value_i,
  input  logic        csr_result_e1_write_i,
  input  logic [31:0] csr_result_e1_wdata_i,
  input  logic [5:0]  csr_result_e1_exception_i,
  input  logic [5:0]  mem_exception_e2_i,
  input  logic [31:0] mem_addr_e2_i,
  input  logic        stall_i,
  input  logic        squash_i,
  output logic        csr_writeback_write_o,
  output logic [11:0] csr_writeback_waddr_o,
  output logic [31:0] csr_writeback_wdata_o,
  output logic [5:0]  csr_writeback_exception_o,
  output logic [31:0] csr_writeback_exception_pc_o,
  output logic [31:0] csr_writeback_exception_addr_o,
  output logic        rd_wb_valid_o,
  output logic [4:0]  rd_wb_idx_o,
  output logic [31:0] rd_wb_value_o,
  output logic        csr_pending_o
);

  localparam logic [5:0] EXC_MISALIGNED_FETCH = 6'h10;
  localparam logic [5:0] EXC_FAULT_FETCH      = 6'h11;
  localparam logic [5:0] EXC_ILLEGAL_INSTR    = 6'h12;
  localparam logic [5:0] EXC_BREAKPOINT       = 6'h13;
  localparam logic [5:0] EXC_MISALIGNED_LOAD  = 6'h14;
  localparam logic [5:0] EXC_FAULT_LOAD       = 6'h15;
  localparam logic [5:0] EXC_MISALIGNED_STORE = 6'h16;
  localparam logic [5:0] EXC_FAULT_STORE      = 6'h17;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] opcode;
    logic [4:0]  rd_idx;
    logic [31:0] value;
    logic        write;
    logic [31:0] wdata;
    logic [5:0]  exception;
  } stage_t;

  stage_t      r_e2;
  stage_t      r_wb;
  logic [31:0] r_wb_exc_addr;

  stage_t      w_e1;
  stage_t      w_wb_next;
  logic [5:0]  w_e2_exc;
  logic [31:0] w_wb_addr_next;
  logic        w_commit;
  logic        w_flush;
  logic        w_unused;

  // Invalid entries are zeroed so idle stages read as all-zero in waveforms.
  assign w_e1 = e1_valid_i ? stage_t'{valid:     1'b1,
                                      pc:        e1_pc_i,
                                      opcode:    e1_opcode_i,
                                      rd_idx:    e1_rd_idx_i,
                                      value:     csr_result_e1_value_i,
                                      write:     csr_result_e1_write_i,
                                      wdata:     csr_result_e1_wdata_i,
                                      exception: csr_result_e1_exception_i}
                           : '0;

  assign w_e2_exc = (r_e2.exception != '0) ? r_e2.exception : mem_exception_e2_i;
  assign w_commit = r_wb.valid & ~stall_i;
  assign w_flush  = w_commit & (r_wb.exception != '0);
  assign w_unused = ^r_wb.opcode[19:0];

  // NOTE: every combinational output gets a default before any branch, so no path leaves it unassigned (no latch).
  always_comb begin
    w_wb_next      = '0;
    w_wb_addr_next = '0;
    if (r_e2.valid) begin
      w_wb_next           = r_e2;
      w_wb_next.exception = w_e2_exc;
      unique case (w_e2_exc)
        EXC_ILLEGAL_INSTR: w_wb_addr_next = r_e2.value;
        EXC_BREAKPOINT:    w_wb_addr_next = r_e2.pc;
        EXC_MISALIGNED_FETCH, EXC_FAULT_FETCH,
        EXC_MISALIGNED_LOAD,  EXC_FAULT_LOAD,
        EXC_MISALIGNED_STORE, EXC_FAULT_STORE:
          w_wb_addr_next = (SUPPORT_SUPER != 0) ? mem_addr_e2_i : 32'h0;
        default:           w_wb_addr_next = 32'h0;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all stages sample pre-edge values together.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_e2          <= '0;
      r_wb          <= '0;
      r_wb_exc_addr <= '0;
    end else if (stall_i) begin
      // A held WB must still commit later; only the younger E2 entry is killed.
      if (squash_i) begin
        r_e2 <= '0;
      end
    end else if (w_flush || squash_i) begin
      r_e2          <= '0;
      r_wb          <= '0;
      r_wb_exc_addr <= '0;
    end else begin
      r_e2          <= w_e1;
      r_wb          <= w_wb_next;
      r_wb_exc_addr <= w_wb_addr_next;
    end
  end

  always_comb begin
    csr_writeback_write_o          = 1'b0;
    csr_writeback_waddr_o          = '0;
    csr_writeback_wdata_o          = '0;
    csr_writeback_exception_o      = '0;
    csr_writeback_exception_pc_o   = '0;
    csr_writeback_exception_addr_o = '0;
    rd_wb_valid_o                  = 1'b0;
    rd_wb_idx_o                    = '0;
    rd_wb_value_o                  = '0;
    if (w_commit) begin
      csr_writeback_waddr_o = r_wb.opcode[31:20];
      csr_writeback_wdata_o = r_wb.wdata;
      if (r_wb.exception == '0) begin
        csr_writeback_write_o = r_wb.write;
        if (r_wb.rd_idx != '0) begin
          rd_wb_valid_o = 1'b1;
          rd_wb_idx_o   = r_wb.rd_idx;
          rd_wb_value_o = r_wb.value;
        end
      end else begin
        csr_writeback_exception_o      = r_wb.exception;
        csr_writeback_exception_pc_o   = r_wb.pc;
        csr_writeback_exception_addr_o = r_wb_exc_addr;
      end
    end
  end

  assign csr_pending_o = (r_e2.valid & r_e2.write) | (r_wb.valid & r_wb.write);

endmodule

// File: tb/tb_biriscv_csr_wb_pipe.sv
// Directed bench for biriscv_csr_wb_pipe; a second instance with SUPPORT_SUPER=0
// shares the stimulus to check the machine-mode trap value.
module tb_biriscv_csr_wb_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        e1_valid;
  logic [31:0] e1_pc;
  logic [31:0] e1_opcode;
  logic [4:0]  e1_rd_idx;
  logic [31:0] e1_value;
  logic        e1_write;
  logic [31:0] e1_wdata;
  logic [5:0]  e1_exc;
  logic [5:0]  mem_exc;
  logic [31:0] mem_addr;
  logic        stall;
  logic        squash;

  logic        wb_write, m_write;
  logic [11:0] wb_waddr, m_waddr;
  logic [31:0] wb_wdata, m_wdata;
  logic [5:0]  wb_exc, m_exc;
  logic [31:0] wb_exc_pc, m_exc_pc;
  logic [31:0] wb_exc_addr, m_exc_addr;
  logic        rd_valid, m_rd_valid;
  logic [4:0]  rd_idx, m_rd_idx;
  logic [31:0] rd_value, m_rd_value;
  logic        pending, m_pending;

  int n_tests = 0;
  int n_fail  = 0;

  wire [153:0] all_out = {wb_write, wb_waddr, wb_wdata, wb_exc, wb_exc_pc, wb_exc_addr,
                          rd_valid, rd_idx, rd_value, pending};
  wire [153:0] m_all_out = {m_write, m_waddr, m_wdata, m_exc, m_exc_pc, m_exc_addr,
                            m_rd_valid, m_rd_idx, m_rd_value, m_pending};

  always #5 clk = ~clk;

  biriscv_csr_wb_pipe #(.SUPPORT_SUPER(1)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .e1_valid_i(e1_valid), .e1_pc_i(e1_pc), .e1_opcode_i(e1_opcode), .e1_rd_idx_i(e1_rd_idx),
    .csr_result_e1_value_i(e1_value), .csr_result_e1_write_i(e1_write),
    .csr_result_e1_wdata_i(e1_wdata), .csr_result_e1_exception_i(e1_exc),
    .mem_exception_e2_i(mem_exc), .mem_addr_e2_i(mem_addr),
    .stall_i(stall), .squash_i(squash),
    .csr_writeback_write_o(wb_write), .csr_writeback_waddr_o(wb_waddr),
    .csr_writeback_wdata_o(wb_wdata), .csr_writeback_exception_o(wb_exc),
    .csr_writeback_exception_pc_o(wb_exc_pc), .csr_writeback_exception_addr_o(wb_exc_addr),
    .rd_wb_valid_o(rd_valid), .rd_wb_idx_o(rd_idx), .rd_wb_value_o(rd_value),
    .csr_pending_o(pending)
  );

  biriscv_csr_wb_pipe #(.SUPPORT_SUPER(0)) u_dut_m (
    .clk_i(clk), .rst_i(rst),
    .e1_valid_i(e1_valid), .e1_pc_i(e1_pc), .e1_opcode_i(e1_opcode), .e1_rd_idx_i(e1_rd_idx),
    .csr_result_e1_value_i(e1_value), .csr_result_e1_write_i(e1_write),
    .csr_result_e1_wdata_i(e1_wdata), .csr_result_e1_exception_i(e1_exc),
    .mem_exception_e2_i(mem_exc), .mem_addr_e2_i(mem_addr),
    .stall_i(stall), .squash_i(squash),
    .csr_writeback_write_o(m_write), .csr_writeback_waddr_o(m_waddr),
    .csr_writeback_wdata_o(m_wdata), .csr_writeback_exception_o(m_exc),
    .csr_writeback_exception_pc_o(m_exc_pc), .csr_writeback_exception_addr_o(m_exc_addr),
    .rd_wb_valid_o(m_rd_valid), .rd_wb_idx_o(m_rd_idx), .rd_wb_value_o(m_rd_value),
    .csr_pending_o(m_pending)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_e1(input logic [31:0] pc, input logic [31:0] op, input logic [4:0] rd,
                        input logic [31:0] val, input logic wr, input logic [31:0] wd,
                        input logic [5:0] exc);
    e1_valid = 1'b1; e1_pc = pc; e1_opcode = op; e1_rd_idx = rd;
    e1_value = val; e1_write = wr; e1_wdata = wd; e1_exc = exc;
  endtask

  task automatic idle_e1();
    e1_valid = 1'b0; e1_pc = '0; e1_opcode = '0; e1_rd_idx = '0;
    e1_value = '0; e1_write = 1'b0; e1_wdata = '0; e1_exc = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; squash = 1'b0; mem_exc = '0; mem_addr = '0;
    set_e1(32'h8000_0000, 32'h3402_92F3, 5'd5, 32'h11, 1'b1, 32'h1, 6'h0);
    tick(); tick();
    n_tests++;
    if (all_out !== '0) begin n_fail++; $display("FAIL reset_out: got %h expected 0", all_out); end
    n_tests++;
    if (m_all_out !== '0) begin n_fail++; $display("FAIL reset_out_m: got %h expected 0", m_all_out); end
    idle_e1();
    rst = 1'b0;
    tick();
    n_tests++;
    if (all_out !== '0) begin n_fail++; $display("FAIL post_reset_out: got %h expected 0", all_out); end
  endtask

  task automatic test_csr_write();
    set_e1(32'h8000_0000, 32'h3402_92F3, 5'd5, 32'h11, 1'b1, 32'hDEAD_BEEF, 6'h0);
    #1;
    n_tests++;
    if ({wb_write, pending} !== 2'b00) begin
      n_fail++; $display("FAIL csrw_c1: got write/pending %b expected 00", {wb_write, pending});
    end
    tick(); idle_e1(); #1;
    n_tests++;
    if ({wb_write, pending} !== 2'b01) begin
      n_fail++; $display("FAIL csrw_c2: got write/pending %b expected 01", {wb_write, pending});
    end
    tick();
    n_tests++;
    if ({wb_write, wb_waddr, wb_wdata, rd_valid, rd_idx, rd_value, wb_exc} !==
        {1'b1, 12'h340, 32'hDEAD_BEEF, 1'b1, 5'd5, 32'h11, 6'h0}) begin
      n_fail++;
      $display("FAIL csrw_commit: got w=%b a=%h d=%h rv=%b ri=%0d val=%h exc=%h expected w=1 a=340 d=deadbeef rv=1 ri=5 val=11 exc=0",
               wb_write, wb_waddr, wb_wdata, rd_valid, rd_idx, rd_value, wb_exc);
    end
    tick();
    n_tests++;
    if (all_out !== '0) begin n_fail++; $display("FAIL csrw_after: got %h expected 0", all_out); end
  endtask

  task automatic test_illegal_flush();
    set_e1(32'h8000_0100, 32'hFFFF_FFFF, 5'd1, 32'hFFFF_FFFF, 1'b0, 32'h0, 6'h12);
    tick();
    set_e1(32'h8000_0104, 32'h3402_92F3, 5'd7, 32'h77, 1'b1, 32'h1, 6'h0);
    tick();
    set_e1(32'h8000_0108, 32'h3412_9473, 5'd8, 32'h88, 1'b1, 32'h2, 6'h0);
    #1;
    n_tests++;
    if ({wb_exc, wb_exc_pc, wb_exc_addr, wb_write, rd_valid} !==
        {6'h12, 32'h8000_0100, 32'hFFFF_FFFF, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL illegal_commit: got exc=%h pc=%h addr=%h w=%b rv=%b expected exc=12 pc=80000100 addr=ffffffff w=0 rv=0",
               wb_exc, wb_exc_pc, wb_exc_addr, wb_write, rd_valid);
    end
    tick(); idle_e1();
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++;
      if (all_out !== '0) begin n_fail++; $display("FAIL illegal_flush_%0d: got %h expected 0", i, all_out); end
      tick();
    end
  endtask

  task automatic test_mem_fault();
    // Load fault merged in E2: trap value depends on SUPPORT_SUPER.
    set_e1(32'h0000_0200, 32'h0030_A183, 5'd3, 32'h0, 1'b0, 32'h0, 6'h0);
    tick(); idle_e1();
    mem_exc = 6'h14; mem_addr = 32'h0000_1003;
    tick();
    mem_exc = '0; mem_addr = '0; #1;
    n_tests++;
    if ({wb_exc, wb_exc_pc, wb_exc_addr, rd_valid} !== {6'h14, 32'h200, 32'h1003, 1'b0}) begin
      n_fail++;
      $display("FAIL load_fault: got exc=%h pc=%h addr=%h rv=%b expected exc=14 pc=200 addr=1003 rv=0",
               wb_exc, wb_exc_pc, wb_exc_addr, rd_valid);
    end
    n_tests++;
    if ({m_exc, m_exc_addr} !== {6'h14, 32'h0}) begin
      n_fail++; $display("FAIL load_fault_m: got exc=%h addr=%h expected exc=14 addr=0", m_exc, m_exc_addr);
    end
    tick();
    // E1 breakpoint wins over a simultaneous LSU fault.
    set_e1(32'h0000_0300, 32'h0010_0073, 5'd0, 32'h0010_0073, 1'b0, 32'h0, 6'h13);
    tick(); idle_e1();
    mem_exc = 6'h14; mem_addr = 32'h0000_2000;
    tick();
    mem_exc = '0; mem_addr = '0; #1;
    n_tests++;
    if ({wb_exc, wb_exc_pc, wb_exc_addr, m_exc_addr} !== {6'h13, 32'h300, 32'h300, 32'h300}) begin
      n_fail++;
      $display("FAIL breakpoint: got exc=%h pc=%h addr=%h addr_m=%h expected exc=13 pc=300 addr=300 addr_m=300",
               wb_exc, wb_exc_pc, wb_exc_addr, m_exc_addr);
    end
    tick();
    set_e1(32'h0000_0400, 32'h3020_0073, 5'd0, 32'h0, 1'b1, 32'h55, 6'h30);
    tick(); idle_e1(); tick();
    n_tests++;
    if ({wb_exc, wb_exc_pc, wb_exc_addr, wb_write, pending} !== {6'h30, 32'h400, 32'h0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL eret: got exc=%h pc=%h addr=%h w=%b pend=%b expected exc=30 pc=400 addr=0 w=0 pend=1",
               wb_exc, wb_exc_pc, wb_exc_addr, wb_write, pending);
    end
    tick();
  endtask

  task automatic test_stall();
    int pulses = 0;
    set_e1(32'h0000_0500, 32'h3402_9073, 5'd0, 32'h0, 1'b1, 32'h1234_5678, 6'h0);
    tick(); idle_e1(); tick();
    for (int i = 0; i < 3; i++) begin
      stall = 1'b1; #1;
      if (wb_write) pulses++;
      n_tests++;
      if ({wb_write, pending} !== 2'b01) begin
        n_fail++; $display("FAIL stall_hold_%0d: got write/pending %b expected 01", i, {wb_write, pending});
      end
      tick();
    end
    stall = 1'b0; #1;
    if (wb_write) pulses++;
    n_tests++;
    if ({wb_write, wb_waddr, wb_wdata, pending} !== {1'b1, 12'h340, 32'h1234_5678, 1'b1}) begin
      n_fail++;
      $display("FAIL stall_release: got w=%b a=%h d=%h pend=%b expected w=1 a=340 d=12345678 pend=1",
               wb_write, wb_waddr, wb_wdata, pending);
    end
    tick();
    if (wb_write) pulses++;
    n_tests++;
    if (pulses !== 1 || pending !== 1'b0) begin
      n_fail++; $display("FAIL stall_pulses: got %0d pend=%b expected 1 pend=0", pulses, pending);
    end
  endtask

  task automatic test_back_to_back();
    set_e1(32'h600, 32'h3002_9073, 5'd1, 32'hA1, 1'b1, 32'h1, 6'h0);
    tick();
    set_e1(32'h604, 32'h3412_9073, 5'd0, 32'hA2, 1'b1, 32'h2, 6'h0);
    tick();
    set_e1(32'h608, 32'h3422_9073, 5'd3, 32'hA3, 1'b0, 32'h3, 6'h0);
    #1;
    n_tests++;
    if ({wb_write, wb_waddr, wb_wdata, rd_valid, rd_idx, rd_value} !==
        {1'b1, 12'h300, 32'h1, 1'b1, 5'd1, 32'hA1}) begin
      n_fail++; $display("FAIL b2b_1: got w=%b a=%h d=%h rv=%b ri=%0d val=%h expected w=1 a=300 d=1 rv=1 ri=1 val=a1",
                         wb_write, wb_waddr, wb_wdata, rd_valid, rd_idx, rd_value);
    end
    tick(); idle_e1(); #1;
    n_tests++;
    if ({wb_write, wb_waddr, wb_wdata, rd_valid} !== {1'b1, 12'h341, 32'h2, 1'b0}) begin
      n_fail++; $display("FAIL b2b_2: got w=%b a=%h d=%h rv=%b expected w=1 a=341 d=2 rv=0",
                         wb_write, wb_waddr, wb_wdata, rd_valid);
    end
    tick();
    n_tests++;
    if ({wb_write, rd_valid, rd_idx, rd_value} !== {1'b0, 1'b1, 5'd3, 32'hA3}) begin
      n_fail++; $display("FAIL b2b_3: got w=%b rv=%b ri=%0d val=%h expected w=0 rv=1 ri=3 val=a3",
                         wb_write, rd_valid, rd_idx, rd_value);
    end
    tick();
    n_tests++;
    if (all_out !== '0) begin n_fail++; $display("FAIL b2b_after: got %h expected 0", all_out); end
  endtask

  task automatic test_squash();
    set_e1(32'h700, 32'h3002_9073, 5'd0, 32'h0, 1'b1, 32'hC0, 6'h0);
    tick();
    set_e1(32'h704, 32'h3412_9073, 5'd0, 32'h0, 1'b1, 32'hC1, 6'h0);
    tick();
    set_e1(32'h708, 32'h3422_9073, 5'd0, 32'h0, 1'b1, 32'hC2, 6'h0);
    squash = 1'b1; #1;
    n_tests++;
    if ({wb_write, wb_waddr, wb_wdata} !== {1'b1, 12'h300, 32'hC0}) begin
      n_fail++; $display("FAIL squash_older: got w=%b a=%h d=%h expected w=1 a=300 d=c0", wb_write, wb_waddr, wb_wdata);
    end
    tick(); squash = 1'b0; idle_e1();
    for (int i = 0; i < 2; i++) begin
      #1;
      n_tests++;
      if (all_out !== '0) begin n_fail++; $display("FAIL squash_kill_%0d: got %h expected 0", i, all_out); end
      tick();
    end
  endtask

  task automatic test_squash_stall();
    set_e1(32'h800, 32'h3002_9073, 5'd0, 32'h0, 1'b1, 32'hD0, 6'h0);
    tick();
    set_e1(32'h804, 32'h3412_9073, 5'd0, 32'h0, 1'b1, 32'hD1, 6'h0);
    tick(); idle_e1();
    stall = 1'b1; squash = 1'b1; #1;
    n_tests++;
    if ({wb_write, pending} !== 2'b01) begin
      n_fail++; $display("FAIL sqstall_hold: got write/pending %b expected 01", {wb_write, pending});
    end
    tick(); stall = 1'b0; squash = 1'b0; #1;
    n_tests++;
    if ({wb_write, wb_waddr, wb_wdata} !== {1'b1, 12'h300, 32'hD0}) begin
      n_fail++; $display("FAIL sqstall_commit: got w=%b a=%h d=%h expected w=1 a=300 d=d0", wb_write, wb_waddr, wb_wdata);
    end
    tick();
    n_tests++;
    if (all_out !== '0) begin n_fail++; $display("FAIL sqstall_after: got %h expected 0", all_out); end
  endtask

  task automatic test_reset_mid();
    set_e1(32'h900, 32'h3002_9073, 5'd4, 32'h44, 1'b1, 32'hE0, 6'h0);
    tick();
    set_e1(32'h904, 32'h3412_9073, 5'd6, 32'h66, 1'b1, 32'hE1, 6'h0);
    tick(); idle_e1();
    rst = 1'b1; #1;
    n_tests++;
    if (all_out !== '0 || m_all_out !== '0) begin
      n_fail++; $display("FAIL reset_mid: got %h / %h expected 0", all_out, m_all_out);
    end
    tick(); rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_tests++;
      if (all_out !== '0) begin n_fail++; $display("FAIL reset_release_%0d: got %h expected 0", i, all_out); end
    end
  endtask

  initial begin
    test_reset();
    test_csr_write();
    test_illegal_flush();
    test_mem_fault();
    test_stall();
    test_back_to_back();
    test_squash();
    test_squash_stall();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
